// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the instruction prefetch queue.
// The sizing helpers and the queue-operation encoding live here.
package fetch_queue_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int INSTR_BYTES   = 4;

  // Encoding is {push, pop}, so a 2-bit vector casts straight to this type.
  typedef enum logic [1:0] {
    FQ_IDLE = 2'b00,
    FQ_POP  = 2'b01,
    FQ_PUSH = 2'b10,
    FQ_BOTH = 2'b11
  } fq_op_e;

  function automatic int entry_width(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through circular buffer holding {address, instruction} entries.
// Storage is never reset; the head output reads zero whenever the buffer is empty.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  fq_op_e           op;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // When full, a write is only legal because the head slot frees this cycle.
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    op       = fq_op_e'({do_push, do_pop});
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case (op)
        FQ_PUSH: count_d = count_q + CNT_W'(1);
        FQ_POP:  count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = (count_q != '0) ? mem[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: fetch-PC register, push/pop decision and I-cache miss
// signalling in front of a first-word-fall-through prefetch buffer.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = DEFAULT_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Redirect,
  input  logic [ADDR_W-1:0]            RedirectAddr,
  output logic [ADDR_W-1:0]            Icache_addr,
  input  logic [DATA_W-1:0]            Icache_data,
  input  logic                         Icache_hit,
  output logic                         Imiss,
  input  logic                         IF_ID_Stall,
  output logic                         Valid,
  output logic [DATA_W-1:0]            IR,
  output logic [ADDR_W-1:0]            InstrAddr,
  output logic [ADDR_W-1:0]            PC,
  output logic [$clog2(DEPTH+1)-1:0]   Count
);

  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = entry_width(ADDR_W, DATA_W);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               push, pop;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   count;
  logic               valid;

  assign valid = (count != '0);

  // A redirect squashes both ends of the queue for the cycle it is asserted.
  always_comb begin
    pop   = Rst && valid && !IF_ID_Stall && !Redirect;
    push  = Rst && Icache_hit && !Redirect && ((count < CNT_W'(DEPTH)) || pop);
    Imiss = Rst && !Icache_hit && !Redirect;
    pc_d  = pc_q;
    if (Redirect) begin
      pc_d = RedirectAddr;
    end else if (push) begin
      pc_d = pc_q + ADDR_W'(INSTR_BYTES);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (Rst),
    .clear (Redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({pc_q, Icache_data}),
    .rdata (head),
    .count (count)
  );

  assign Icache_addr = pc_q;
  assign Valid       = valid;
  assign IR          = head[DATA_W-1:0];
  assign InstrAddr   = head[ENTRY_W-1:DATA_W];
  assign PC          = valid ? (head[ENTRY_W-1:DATA_W] + ADDR_W'(INSTR_BYTES)) : '0;
  assign Count       = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed vector table plus a short scoreboarded sequence for the fetch queue.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] raddr = '0;
  logic        hit = 1'b0;
  logic        stall = 1'b1;
  logic [31:0] icache_addr, icache_data, ir, instr_addr, pc;
  logic        imiss, valid;
  logic [2:0]  count;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // I-cache model: every address returns a word derived from the address.
  assign icache_data = icache_addr ^ 32'hDEAD_BEEF;

  fetch_queue dut (
    .Clk          (clk),
    .Rst          (rst_n),
    .Redirect     (redirect),
    .RedirectAddr (raddr),
    .Icache_addr  (icache_addr),
    .Icache_data  (icache_data),
    .Icache_hit   (hit),
    .Imiss        (imiss),
    .IF_ID_Stall  (stall),
    .Valid        (valid),
    .IR           (ir),
    .InstrAddr    (instr_addr),
    .PC           (pc),
    .Count        (count)
  );

  typedef struct {
    logic        rst_n;
    logic        redir;
    logic [31:0] raddr;
    logic        hit;
    logic        stall;
    logic [31:0] ia;
    logic        imiss;
    logic        valid;
    logic [31:0] iaddr;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] e_ia, input logic e_imiss,
                               input logic e_valid, input logic [31:0] e_iaddr, input logic [2:0] e_cnt);
    logic [31:0] e_pc, e_ir;
    e_pc = e_valid ? (e_iaddr + 32'd4) : 32'd0;
    e_ir = e_valid ? (e_iaddr ^ 32'hDEAD_BEEF) : 32'd0;
    chk({tag, " icache_addr"}, icache_addr, e_ia);
    chk({tag, " imiss"},       32'(imiss), 32'(e_imiss));
    chk({tag, " valid"},       32'(valid), 32'(e_valid));
    chk({tag, " instr_addr"},  instr_addr, e_valid ? e_iaddr : 32'd0);
    chk({tag, " pc"},          pc, e_pc);
    chk({tag, " ir"},          ir, e_ir);
    chk({tag, " count"},       32'(count), 32'(e_cnt));
  endtask

  logic [31:0] pc_m;
  logic [31:0] q_m[$];
  logic        pop_m, push_m;

  initial begin
    // rst, redir, raddr, hit, stall | icache_addr, imiss, valid, instr_addr, count
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         3'd0});
    // fill with IF/ID stalled: 0,4,8,12 queued, then back-pressure at 16
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,         3'd0});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         1'b0, 1'b1, 32'h0,         3'd1});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         1'b0, 1'b1, 32'h0,         3'd2});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hC,         1'b0, 1'b1, 32'h0,         3'd3});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10,        1'b0, 1'b1, 32'h0,         3'd4});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10,        1'b0, 1'b1, 32'h0,         3'd4});
    // full queue streaming: pop and push every cycle
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h10,        1'b0, 1'b1, 32'h0,         3'd4});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h14,        1'b0, 1'b1, 32'h4,         3'd4});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h18,        1'b0, 1'b1, 32'h8,         3'd4});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h1C,        1'b0, 1'b1, 32'hC,         3'd4});
    // three misses at 0x20, then drain while missing
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h20,        1'b1, 1'b1, 32'h10,        3'd4});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h20,        1'b1, 1'b1, 32'h10,        3'd4});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h20,        1'b1, 1'b1, 32'h10,        3'd4});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h20,        1'b1, 1'b1, 32'h10,        3'd4});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h20,        1'b1, 1'b1, 32'h14,        3'd3});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h20,        1'b0, 1'b1, 32'h18,        3'd2});
    // redirect with Count=3 and a hit present
    vecs.push_back('{1'b1, 1'b1, 32'h100,       1'b1, 1'b0, 32'h24,        1'b0, 1'b1, 32'h18,        3'd3});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h100,       1'b0, 1'b0, 32'h0,         3'd0});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h104,       1'b1, 1'b1, 32'h100,       3'd1});
    // push+pop at Count=1, then drain and attempt pop when empty
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h104,       1'b0, 1'b1, 32'h100,       3'd1});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h108,       1'b1, 1'b1, 32'h104,       3'd1});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h108,       1'b1, 1'b0, 32'h0,         3'd0});
    // redirect while missing: Imiss suppressed; then address wrap
    vecs.push_back('{1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 32'h108,       1'b0, 1'b0, 32'h0,         3'd0});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 32'h0,         3'd0});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFFFF_FFF8, 3'd1});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFF8, 3'd2});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 3'd1});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFC, 3'd1});
    // reset beats a simultaneous redirect with Count=2
    vecs.push_back('{1'b0, 1'b1, 32'h200,       1'b1, 1'b0, 32'h4,         1'b0, 1'b1, 32'hFFFF_FFFC, 3'd2});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,         3'd0});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,         3'd0});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h4,         1'b0, 1'b1, 32'h0,         3'd1});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8,         1'b1, 1'b1, 32'h4,         3'd1});

    rst_n = 1'b0;
    hit   = 1'b1;
    stall = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n    = vecs[i].rst_n;
      redirect = vecs[i].redir;
      raddr    = vecs[i].raddr;
      hit      = vecs[i].hit;
      stall    = vecs[i].stall;
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].ia, vecs[i].imiss, vecs[i].valid,
                    vecs[i].iaddr, vecs[i].cnt);
      $display("vec %0d: ia=%h imiss=%0b valid=%0b instr_addr=%h pc=%h count=%0d",
               i, icache_addr, imiss, valid, instr_addr, pc, count);
    end

    // Scoreboarded sequence: random hit/stall, strict fetch order from 0x40.
    @(negedge clk);
    rst_n    = 1'b1;
    redirect = 1'b1;
    raddr    = 32'h40;
    hit      = 1'b0;
    stall    = 1'b1;
    pc_m     = 32'h40;
    q_m.delete();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      redirect = 1'b0;
      hit      = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 2) == 0);
      #1;
      pop_m  = (q_m.size() != 0) && !stall;
      push_m = hit && ((q_m.size() < 4) || pop_m);
      check_outputs($sformatf("seq%0d", c), pc_m, !hit, q_m.size() != 0,
                    (q_m.size() != 0) ? q_m[0] : 32'd0, 3'(q_m.size()));
      $display("seq %0d: hit=%0b stall=%0b ia=%h instr_addr=%h count=%0d",
               c, hit, stall, icache_addr, instr_addr, count);
      if (pop_m) void'(q_m.pop_front());
      if (push_m) begin
        q_m.push_back(pc_m);
        pc_m = pc_m + 32'd4;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
